// File: rtl/network_pkg.sv
// Shared widths, defaults and batch FSM state type for the network result collector.
package network_pkg;

    localparam int NET_OUT_W     = 34;
    localparam int BATCH_LEN_DEF = 100;
    localparam int IDX_W         = 7;
    localparam int ENTRY_W       = NET_OUT_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } batch_state_e;

    function automatic logic classify(input logic signed [NET_OUT_W-1:0] value,
                                      input logic signed [NET_OUT_W-1:0] thr);
        return value >= thr;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Result FIFO with first-word-fall-through head, sticky overflow and pop-assisted push when full.
module result_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 35,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [AW:0]      count,
    output logic             overflow
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             overflow_q;
    logic             pop, full, push_ok;

    assign pop     = pop_ready && (count_q != '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    // A push into a full FIFO only lands if the head leaves on the same edge.
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (pop && !push_ok) begin
                count_q <= count_q - (AW+1)'(1);
            end
            if (push && !push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign head_valid = (count_q != '0);
    assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;
    assign overflow   = overflow_q;

endmodule

// File: rtl/network_result_collector.sv
// Collects classified network results into a FIFO and tracks the per-batch maximum and its index.
module network_result_collector
    import network_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int BATCH_LEN = BATCH_LEN_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [NET_OUT_W-1:0] net_out,
    input  logic                        net_end,
    input  logic signed [NET_OUT_W-1:0] threshold,
    output logic signed [NET_OUT_W-1:0] res_value,
    output logic                        res_class,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [$clog2(DEPTH):0]      fill_count,
    output logic                        overflow,
    output logic signed [NET_OUT_W-1:0] batch_max,
    output logic [IDX_W-1:0]            batch_max_idx,
    output logic                        batch_done
);

    localparam int CNT_W = $clog2(BATCH_LEN + 1);

    logic [ENTRY_W-1:0] push_data, head_data;

    assign push_data = {net_out, classify(net_out, threshold)};

    result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (net_end),
        .push_data  (push_data),
        .pop_ready  (res_ready),
        .head_data  (head_data),
        .head_valid (res_valid),
        .count      (fill_count),
        .overflow   (overflow)
    );

    assign res_value = head_data[ENTRY_W-1:1];
    assign res_class = head_data[0];

    batch_state_e                state_q, state_d;
    logic signed [NET_OUT_W-1:0] run_max_q, run_max_d;
    logic [IDX_W-1:0]            run_idx_q, run_idx_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic signed [NET_OUT_W-1:0] batch_max_q, batch_max_d;
    logic [IDX_W-1:0]            batch_idx_q, batch_idx_d;
    logic signed [NET_OUT_W-1:0] smp_max;
    logic [IDX_W-1:0]            smp_idx;
    logic [CNT_W-1:0]            smp_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            run_max_q   <= '0;
            run_idx_q   <= '0;
            count_q     <= '0;
            batch_max_q <= '0;
            batch_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            run_max_q   <= run_max_d;
            run_idx_q   <= run_idx_d;
            count_q     <= count_d;
            batch_max_q <= batch_max_d;
            batch_idx_q <= batch_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        run_max_d   = run_max_q;
        run_idx_d   = run_idx_q;
        count_d     = count_q;
        batch_max_d = batch_max_q;
        batch_idx_d = batch_idx_q;
        smp_max     = net_out;
        smp_idx     = '0;
        smp_cnt     = CNT_W'(1);

        // Running values including the current sample; IDLE and DONE both open a fresh batch.
        if (state_q == ST_COLLECT) begin
            smp_cnt = count_q + CNT_W'(1);
            smp_max = run_max_q;
            smp_idx = run_idx_q;
            if (net_out > run_max_q) begin
                smp_max = net_out;
                smp_idx = IDX_W'(count_q);
            end
        end

        if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end

        if (net_end) begin
            run_max_d = smp_max;
            run_idx_d = smp_idx;
            count_d   = smp_cnt;
            if (smp_cnt == CNT_W'(BATCH_LEN)) begin
                state_d     = ST_DONE;
                batch_max_d = smp_max;
                batch_idx_d = smp_idx;
            end else begin
                state_d = ST_COLLECT;
            end
        end
    end

    assign batch_max     = batch_max_q;
    assign batch_max_idx = batch_idx_q;
    assign batch_done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_network_result_collector.sv
// Self-checking bench: classification table, directed FIFO/batch sequences, randomized run against a queue model.
module tb_network_result_collector;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [33:0] net_out;
    logic               net_end;
    logic signed [33:0] threshold;
    logic signed [33:0] res_value;
    logic               res_class;
    logic               res_valid;
    logic               res_ready;
    logic [3:0]         fill_count;
    logic               overflow;
    logic signed [33:0] batch_max;
    logic [6:0]         batch_max_idx;
    logic               batch_done;

    int n_checks = 0;
    int n_fail   = 0;

    network_result_collector #(
        .DEPTH     (8),
        .BATCH_LEN (100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .net_out       (net_out),
        .net_end       (net_end),
        .threshold     (threshold),
        .res_value     (res_value),
        .res_class     (res_class),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .fill_count    (fill_count),
        .overflow      (overflow),
        .batch_max     (batch_max),
        .batch_max_idx (batch_max_idx),
        .batch_done    (batch_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint val;
        longint thr;
        bit     exp_cls;
    } vec_t;

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        net_end   = 1'b0;
        res_ready = 1'b0;
        net_out   = '0;
        threshold = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_one(input longint v);
        net_out = 34'(v);
        net_end = 1'b1;
        tick();
        net_end = 1'b0;
    endtask

    vec_t   vecs[8];
    int     done_cnt;
    longint q_val[$];
    bit     q_cls[$];
    longint bq[$];
    bit     m_ovf, m_done;
    longint m_bmax;
    longint m_bidx;

    initial begin
        vecs[0] = '{5, 3, 1'b1};
        vecs[1] = '{3, 3, 1'b1};
        vecs[2] = '{2, 3, 1'b0};
        vecs[3] = '{-1, 0, 1'b0};
        vecs[4] = '{0, -1, 1'b1};
        vecs[5] = '{64'sd8589934591, -64'sd8589934592, 1'b1};
        vecs[6] = '{-64'sd8589934592, 64'sd8589934591, 1'b0};
        vecs[7] = '{-5, -5, 1'b1};

        // Reset state
        do_reset();
        check("rst_fill", fill_count, 0);
        check("rst_valid", res_valid, 0);
        check("rst_value", res_value, 0);
        check("rst_class", res_class, 0);
        check("rst_ovf", overflow, 0);
        check("rst_bmax", batch_max, 0);
        check("rst_bidx", batch_max_idx, 0);
        check("rst_bdone", batch_done, 0);

        // Classification table: push with ready held, visible next cycle, gone the cycle after
        foreach (vecs[i]) begin
            threshold = 34'(vecs[i].thr);
            res_ready = 1'b1;
            push_one(vecs[i].val);
            check($sformatf("tbl%0d_valid", i), res_valid, 1);
            check($sformatf("tbl%0d_value", i), res_value, vecs[i].val);
            check($sformatf("tbl%0d_class", i), res_class, longint'(vecs[i].exp_cls));
            tick();
            check($sformatf("tbl%0d_popped", i), res_valid, 0);
            $display("vector %0d: value=%0d thr=%0d class=%0d", i, vecs[i].val, vecs[i].thr, res_class);
        end

        // Overflow: nine pushes into an eight-deep FIFO, then drain in order
        do_reset();
        for (int i = 0; i < 9; i++) push_one(10 + i);
        check("ovf_fill", fill_count, 8);
        check("ovf_flag", overflow, 1);
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf_drain%0d", i), res_value, 10 + i);
            tick();
        end
        check("ovf_empty", res_valid, 0);
        check("ovf_sticky", overflow, 1);
        $display("overflow sequence: drained 8, overflow=%0d", overflow);

        // Simultaneous push/pop at partial and full occupancy
        do_reset();
        for (int i = 1; i <= 4; i++) push_one(i);
        res_ready = 1'b1;
        push_one(5);
        res_ready = 1'b0;
        check("pp_partial_fill", fill_count, 4);
        for (int i = 6; i <= 9; i++) push_one(i);
        check("pp_full_fill", fill_count, 8);
        res_ready = 1'b1;
        push_one(10);
        res_ready = 1'b0;
        check("pp_fullpop_fill", fill_count, 8);
        check("pp_fullpop_ovf", overflow, 0);
        res_ready = 1'b1;
        for (int i = 3; i <= 10; i++) begin
            check($sformatf("pp_drain%0d", i), res_value, i);
            tick();
        end
        check("pp_empty", fill_count, 0);
        $display("push/pop sequence: fill stayed 8, overflow=%0d", overflow);

        // Batch max with a tie: first occurrence wins
        do_reset();
        res_ready = 1'b1;
        done_cnt  = 0;
        for (int i = 0; i < 100; i++) begin
            push_one((i == 42 || i == 70) ? 1000 : i);
            if (batch_done) done_cnt++;
            if (i == 98) check("batch_hold_before", batch_max, 0);
            if (i == 99) check("batch_done_pulse", batch_done, 1);
        end
        check("batch_max", batch_max, 1000);
        check("batch_idx", batch_max_idx, 42);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (batch_done) done_cnt++;
        end
        check("batch_done_once", done_cnt, 1);
        check("batch_max_hold", batch_max, 1000);
        $display("batch sequence: max=%0d idx=%0d pulses=%0d", batch_max, batch_max_idx, done_cnt);

        // Reset mid-batch with a concurrent net_end, then an all-negative batch
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 50; i++) push_one(500);
        rst     = 1'b1;
        net_end = 1'b1;
        tick();
        rst     = 1'b0;
        net_end = 1'b0;
        check("midrst_fill", fill_count, 0);
        check("midrst_valid", res_valid, 0);
        res_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            push_one(-7);
            if (i == 98) check("neg_not_done", batch_done, 0);
        end
        check("neg_done", batch_done, 1);
        check("neg_max", batch_max, -7);
        check("neg_idx", batch_max_idx, 0);
        $display("reset sequence: max=%0d idx=%0d", batch_max, batch_max_idx);

        // Randomized run against a queue/array model
        do_reset();
        m_ovf  = 1'b0;
        m_bmax = 0;
        m_bidx = 0;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            longint v, t;
            logic [63:0] r;
            bit full, pop;
            net_end   = ($urandom_range(0, 9) < 7);
            res_ready = ($urandom_range(0, 9) < (((cyc / 100) % 2 == 1) ? 8 : 3));
            if ($urandom_range(0, 9) == 0) begin
                r = {$urandom(), $urandom()};
                net_out = r[33:0];
            end else begin
                net_out = 34'($signed($urandom_range(0, 40)) - 20);
            end
            threshold = 34'($signed($urandom_range(0, 20)) - 10);
            v = net_out;
            t = threshold;

            m_done = 1'b0;
            full = (q_val.size() == 8);
            pop  = res_ready && (q_val.size() > 0);
            if (pop) begin
                void'(q_val.pop_front());
                void'(q_cls.pop_front());
            end
            if (net_end) begin
                if (!full || pop) begin
                    q_val.push_back(v);
                    q_cls.push_back(v >= t);
                end else begin
                    m_ovf = 1'b1;
                end
                bq.push_back(v);
                if (bq.size() == 100) begin
                    m_bmax = bq[0];
                    m_bidx = 0;
                    for (int k = 1; k < 100; k++) begin
                        if (bq[k] > m_bmax) begin
                            m_bmax = bq[k];
                            m_bidx = k;
                        end
                    end
                    m_done = 1'b1;
                    bq.delete();
                end
            end

            tick();
            net_end = 1'b0;
            check("rnd_fill", fill_count, q_val.size());
            check("rnd_valid", res_valid, longint'(q_val.size() > 0));
            if (q_val.size() > 0) begin
                check("rnd_value", res_value, q_val[0]);
                check("rnd_class", res_class, longint'(q_cls[0]));
            end
            check("rnd_ovf", overflow, longint'(m_ovf));
            check("rnd_done", batch_done, longint'(m_done));
            check("rnd_bmax", batch_max, m_bmax);
            check("rnd_bidx", batch_max_idx, m_bidx);
            if (m_done) $display("random batch at cycle %0d: max=%0d idx=%0d", cyc, m_bmax, m_bidx);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
